rgb_to_yuv_pipe: RTL and testbench
==================================

RGB_TO_YUV_PIPE -- requirements
Module: rgb_to_yuv_pipe

Interface
REQ-001 The module SHALL have one parameter, DATA_W, default 8, legal range 8..12: component width of R/G/B/Y/U/V.
REQ-002 The ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_709  in  1  0 = BT.601 coefficients, 1 = BT.709.
- cfg_422  in  1  0 = 4:4:4 output, 1 = 4:2:2 interleaved chroma output.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_r, s_g, s_b  in  DATA_W  unsigned RGB.
- s_last  in  1  last pixel of line.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat consumed when m_valid && m_ready.
- m_y  out  DATA_W  luma.
- m_u  out  DATA_W  U (4:4:4) or interleaved Cb/Cr (4:2:2).
- m_v  out  DATA_W  V (4:4:4), 0 in 4:2:2.
- m_last  out  1  last beat of line.

Function
REQ-003 Coefficients SHALL use 8 fractional bits. BT.601: Y = 77R+150G+29B; U = -43R-85G+128B; V = 128R-107G-21B. BT.709: Y = 54R+183G+19B; U = -29R-99G+128B; V = 128R-116G-12B.
REQ-004 Each sum SHALL be formed signed, without overflow, with +128 added, then arithmetic-shifted right 8 (floor).
REQ-005 U and V SHALL then add MID = 2^(DATA_W-1).
REQ-006 All three results SHALL be clamped to [0, 2^DATA_W-1].
REQ-007 The pipeline SHALL have three register stages: products; sum/round/clamp; output buffer.
REQ-008 4:4:4 latency SHALL be 3 cycles from input transfer to m_valid, with m_ready held high.
REQ-009 Throughput SHALL be one pixel per cycle in both modes when m_ready is high.
REQ-010 All stages SHALL advance on a common enable; s_ready SHALL equal that enable. The enable is high when the output buffer can accept the stage-2 result in the same cycle.
REQ-011 When m_ready is low, the output beat and all fields SHALL hold stable; no beat is dropped or duplicated.
REQ-012 cfg_709 and cfg_422 SHALL be sampled on the first accepted pixel of each line, meaning the first after reset or after an accepted s_last. They SHALL be carried with every pixel of that line; changes mid-line SHALL be ignored.
REQ-013 A parity flag SHALL be cleared at line start and toggled on each accepted pixel.
REQ-014 4:2:2 even pixel: results SHALL be held in a pair register; no output is produced.
REQ-015 4:2:2 odd pixel: the output buffer SHALL receive two beats, emitted in order on successive transfers.
- Beat A: m_y = Y_even, m_u = Cb = (U_even+U_odd+1)>>1.
- Beat B: m_y = Y_odd, m_u = Cr = (V_even+V_odd+1)>>1, m_last = s_last of the odd pixel.
REQ-016 Beat A SHALL appear 3 cycles after the odd pixel's input transfer. Beat B SHALL follow on the cycle after beat A transfers.
REQ-017 Beat B SHALL be emitted without waiting for further input (line-end flush). The output buffer SHALL hold 2 entries.
REQ-018 4:2:2 odd-length line: an even pixel with s_last SHALL emit one beat: m_y = Y, m_u = its own U, m_last = 1. Parity SHALL then reset.
REQ-019 m_v SHALL be 0 on every 4:2:2 beat.
REQ-020 In 4:4:4, m_last SHALL equal the s_last of the same pixel.
REQ-021 Simultaneous accept and emit SHALL be supported in all buffer states without a bubble.

Reset
REQ-022 While rst is high at a clock edge, all valid flags, the output buffer, the pair register and parity SHALL clear. Sampled mode SHALL be treated as unsampled.
REQ-023 Reset values SHALL be: m_valid = 0, m_y = m_u = m_v = 0, m_last = 0.
REQ-024 s_ready SHALL be 0 while rst is high and SHALL be 1 on the first cycle after rst deasserts.
REQ-025 A reset mid-line or mid-pair SHALL discard all in-flight data; the next accepted pixel starts a new line.

Verification
REQ-026 601, 4:4:4, DATA_W = 8, RGB = (255,255,255) -> 3 cycles later Y = 255, U = 128, V = 128.
REQ-027 601, 4:4:4, RGB = (255,0,0) -> Y = 77, U = 85, V = 255 (clamped from 256).
REQ-028 709, 4:4:4, RGB = (0,0,255) -> Y = 19, U = 255 (clamped), V = 116.
REQ-029 601, 4:2:2, red then blue with s_last on blue -> beat A Y = 77, m_u = 170; beat B Y = 29, m_u = 181, m_last = 1; m_v = 0 on both.
REQ-030 4:4:4 continuous input with m_ready low for 10 cycles -> s_ready drops within 1 cycle; the output sequence equals the input order with no loss or duplication; fields stable while stalled.
REQ-031 rst asserted after an even 4:2:2 pixel -> next cycle m_valid = 0. The next pixel is treated as even and starts a new line with freshly sampled cfg.

Source files
------------

// File: rtl/rgb_to_yuv_pipe.sv
// RGB to YUV colour-space converter.
// Three register stages (products, sum/round/clamp, 2-entry output buffer)
// share one advance enable, which is also s_ready. The colour standard and
// the chroma mode are captured on the first pixel of each line. In 4:2:2 mode,
// pixel pairs are merged into two beats that carry averaged Cb and Cr.
module rgb_to_yuv_pipe #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_709,
  input  logic              cfg_422,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_r,
  input  logic [DATA_W-1:0] s_g,
  input  logic [DATA_W-1:0] s_b,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_y,
  output logic [DATA_W-1:0] m_u,
  output logic [DATA_W-1:0] m_v,
  output logic              m_last
);

  localparam int PW = DATA_W + 10;  // coefficient (10b signed) x component (DATA_W+1 signed)
  localparam int SW = DATA_W + 11;  // sum of three products plus rounding, never overflows
  localparam logic signed [SW-1:0] RND  = SW'(128);
  localparam logic signed [SW-1:0] MID  = SW'(2 ** (DATA_W - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** DATA_W - 1);

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] v;
    logic              last;
  } beat_t;

  function automatic logic [DATA_W-1:0] clamp(input logic signed [SW-1:0] x);
    if (x < 0)         return '0;
    else if (x > MAXV) return MAXV[DATA_W-1:0];
    else               return x[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] avg(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(1);
    return s[DATA_W:1];
  endfunction

  logic en;
  logic accept;

  // ---------------- line state: mode sampling and parity ----------------
  logic line_start_q, par_q, mode709_q, mode422_q;
  logic px_709, px_422, px_odd;

  assign accept = s_valid && s_ready;
  assign px_709 = line_start_q ? cfg_709 : mode709_q;
  assign px_422 = line_start_q ? cfg_422 : mode422_q;
  assign px_odd = line_start_q ? 1'b0 : par_q;

  // Capture the mode at line start; toggle parity on each accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start_q <= 1'b1;
      par_q        <= 1'b0;
      mode709_q    <= 1'b0;
      mode422_q    <= 1'b0;
    end else if (accept) begin
      if (line_start_q) begin
        mode709_q <= cfg_709;
        mode422_q <= cfg_422;
      end
      par_q        <= s_last ? 1'b0 : ~px_odd;
      line_start_q <= s_last;
    end
  end

  // ---------------- stage 1: products ----------------
  logic signed [9:0]        coef [9];
  logic [DATA_W-1:0]        comp [3];
  logic signed [PW-1:0]     prod_d [9];
  logic signed [PW-1:0]     prod_q [9];
  logic                     v1_q, last1_q, m422_1_q, odd1_q;

  assign comp[0] = s_r;
  assign comp[1] = s_g;
  assign comp[2] = s_b;

  // Select the coefficient set (Y row, U row, V row; R,G,B columns).
  always_comb begin
    coef = '{10'sd77, 10'sd150, 10'sd29, -10'sd43, -10'sd85, 10'sd128, 10'sd128, -10'sd107, -10'sd21};
    if (px_709) begin
      coef = '{10'sd54, 10'sd183, 10'sd19, -10'sd29, -10'sd99, 10'sd128, 10'sd128, -10'sd116, -10'sd12};
    end
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_prod
    assign prod_d[gi] = $signed({1'b0, comp[gi % 3]}) * coef[gi];
  end

  // Stage-1 register: products plus per-pixel sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else if (en) begin
      v1_q     <= s_valid;
      last1_q  <= s_last;
      m422_1_q <= px_422;
      odd1_q   <= px_odd;
      prod_q   <= prod_d;
    end
  end

  // ---------------- stage 2: sum, round, offset, clamp ----------------
  logic signed [SW-1:0] sum_d [3];
  logic [DATA_W-1:0]    res_d [3];
  logic [DATA_W-1:0]    res_q [3];
  logic                 v2_q, last2_q, m422_2_q, odd2_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_sum
    assign sum_d[gi] = (SW'(prod_q[3*gi]) + SW'(prod_q[3*gi+1]) + SW'(prod_q[3*gi+2]) + RND) >>> 8;
    assign res_d[gi] = clamp(sum_d[gi] + ((gi == 0) ? SW'(0) : MID));
  end

  // Stage-2 register: clamped Y/U/V and sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
    end else if (en) begin
      v2_q     <= v1_q;
      last2_q  <= last1_q;
      m422_2_q <= m422_1_q;
      odd2_q   <= odd1_q;
      res_q    <= res_d;
    end
  end

  // ---------------- stage 3: pair register and 2-entry output buffer ----------------
  logic [DATA_W-1:0] pair_q [3];
  beat_t             ent_q [2];
  beat_t             ent_d [2];
  logic [1:0]        cnt_q, cnt_d, base;
  logic [1:0]        need;
  logic [2:0]        free;
  logic              pop;
  beat_t             beat_a, beat_b;

  assign pop     = (cnt_q != 2'd0) && m_ready;
  assign free    = 3'd2 - {1'b0, cnt_q} + {2'b0, pop};
  assign en      = !rst && ({1'b0, need} <= free);
  assign s_ready = en;

  // Work out how many beats the stage-2 pixel produces and what they carry.
  always_comb begin
    need   = 2'd0;
    beat_a = '{y: res_q[0], u: res_q[1], v: res_q[2], last: last2_q};
    beat_b = '{y: res_q[0], u: avg(pair_q[2], res_q[2]), v: '0, last: last2_q};
    if (v2_q) begin
      if (!m422_2_q) begin
        need = 2'd1;
      end else if (odd2_q) begin
        need   = 2'd2;
        beat_a = '{y: pair_q[0], u: avg(pair_q[1], res_q[1]), v: '0, last: 1'b0};
      end else if (last2_q) begin
        need   = 2'd1;
        beat_a = '{y: res_q[0], u: res_q[1], v: '0, last: 1'b1};
      end
    end
  end

  // Buffer next state: pop the head first, then append the new beats.
  always_comb begin
    ent_d = ent_q;
    base  = cnt_q;
    if (pop) begin
      ent_d[0] = ent_q[1];
      base     = cnt_q - 2'd1;
    end
    cnt_d = base;
    if (en && need == 2'd2) begin
      ent_d[0] = beat_a;
      ent_d[1] = beat_b;
      cnt_d    = 2'd2;
    end else if (en && need == 2'd1) begin
      ent_d[base[0]] = beat_a;
      cnt_d          = base + 2'd1;
    end
  end

  // Output buffer and 4:2:2 even-pixel pair register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      ent_q  <= '{default: '0};
      pair_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
      if (en && v2_q && m422_2_q && !odd2_q && !last2_q) begin
        pair_q <= res_q;
      end
    end
  end

  assign m_valid = (cnt_q != 2'd0);
  assign m_y     = ent_q[0].y;
  assign m_u     = ent_q[0].u;
  assign m_v     = ent_q[0].v;
  assign m_last  = ent_q[0].last;

endmodule

// File: tb/tb_rgb_to_yuv_pipe.sv
// Scoreboard bench for rgb_to_yuv_pipe: directed pixels with hand-computed results.
module tb_rgb_to_yuv_pipe;

  logic       clk = 1'b0;
  logic       rst, cfg_709, cfg_422, s_valid, s_ready, s_last;
  logic [7:0] s_r, s_g, s_b;
  logic       m_valid, m_ready, m_last;
  logic [7:0] m_y, m_u, m_v;

  rgb_to_yuv_pipe #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_709(cfg_709), .cfg_422(cfg_422),
    .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_y(m_y), .m_u(m_u), .m_v(m_v), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [7:0] y, u, v, input logic last);
    sb.push_back('{y: y, u: u, v: v, last: last});
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one pixel and hold it until it is accepted (bounded).
  task automatic send(input logic [7:0] r, g, b, input logic last, c709, c422);
    bit ok;
    ok      = 1'b0;
    s_r     = r;
    s_g     = g;
    s_b     = b;
    s_last  = last;
    cfg_709 = c709;
    cfg_422 = c422;
    s_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Monitor: pop and compare every output transfer; check stability while stalled.
  exp_t e;
  exp_t held;
  logic stall_prev = 1'b0;
  int   beat_no    = 0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'b0, m_valid}, 32'd1);
        chk("stall_fields", {7'b0, m_y, m_u, m_v, m_last}, {7'b0, held});
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=y%0d,u%0d,v%0d required=none", m_y, m_u, m_v);
        end else begin
          e = sb.pop_front();
          $display("beat %0d: y=%0d u=%0d v=%0d last=%0d (want %0d %0d %0d %0d)",
                   beat_no, m_y, m_u, m_v, m_last, e.y, e.u, e.v, e.last);
          chk("beat_y", {24'b0, m_y}, {24'b0, e.y});
          chk("beat_u", {24'b0, m_u}, {24'b0, e.u});
          chk("beat_v", {24'b0, m_v}, {24'b0, e.v});
          chk("beat_last", {31'b0, m_last}, {31'b0, e.last});
        end
        beat_no++;
      end
      stall_prev = m_valid && !m_ready;
      held       = '{y: m_y, u: m_u, v: m_v, last: m_last};
    end
  end

  // Colour table for the streaming test with BT.601 4:4:4 results.
  logic [7:0] col_r [6] = '{8'd255, 8'd255, 8'd0,   8'd0,   8'd0,   8'd128};
  logic [7:0] col_g [6] = '{8'd255, 8'd0,   8'd255, 8'd0,   8'd0,   8'd128};
  logic [7:0] col_b [6] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   8'd128};
  logic [7:0] col_y [6] = '{8'd255, 8'd77,  8'd149, 8'd29,  8'd0,   8'd128};
  logic [7:0] col_u [6] = '{8'd128, 8'd85,  8'd43,  8'd255, 8'd128, 8'd128};
  logic [7:0] col_v [6] = '{8'd128, 8'd255, 8'd21,  8'd107, 8'd128, 8'd128};

  initial begin
    rst = 1'b1; cfg_709 = 1'b0; cfg_422 = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_r = '0; s_g = '0; s_b = '0; m_ready = 1'b1;
    cycles(3);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_fields", {7'b0, m_y, m_u, m_v, m_last}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", {31'b0, s_ready}, 32'd1);
    cycles(1);

    // White, 601, 4:4:4, with latency check.
    expect_beat(8'd255, 8'd128, 8'd128, 1'b1);
    send(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
    chk("lat_stage1", {31'b0, m_valid}, 32'd0);
    cycles(1);
    chk("lat_stage2", {31'b0, m_valid}, 32'd0);
    cycles(1);
    chk("lat_stage3", {31'b0, m_valid}, 32'd1);
    cycles(2);

    // Red 601 (V clamps), blue 709 (U clamps).
    expect_beat(8'd77, 8'd85, 8'd255, 1'b1);
    send(8'd255, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    expect_beat(8'd19, 8'd255, 8'd116, 1'b1);
    send(8'd0, 8'd0, 8'd255, 1'b1, 1'b1, 1'b0);

    // Mode change mid-line is ignored.
    expect_beat(8'd255, 8'd128, 8'd128, 1'b0);
    send(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
    expect_beat(8'd77, 8'd85, 8'd255, 1'b1);
    send(8'd255, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    cycles(4);

    // 4:2:2 pair: red then blue (last).
    expect_beat(8'd77, 8'd170, 8'd0, 1'b0);
    expect_beat(8'd29, 8'd181, 8'd0, 1'b1);
    send(8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    send(8'd0, 8'd0, 8'd255, 1'b1, 1'b0, 1'b1);

    // 4:2:2 four-pixel line back to back: red, blue, green, white(last).
    expect_beat(8'd77, 8'd170, 8'd0, 1'b0);
    expect_beat(8'd29, 8'd181, 8'd0, 1'b0);
    expect_beat(8'd149, 8'd86, 8'd0, 1'b0);
    expect_beat(8'd255, 8'd75, 8'd0, 1'b1);
    send(8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    send(8'd0, 8'd0, 8'd255, 1'b0, 1'b0, 1'b1);
    send(8'd0, 8'd255, 8'd0, 1'b0, 1'b0, 1'b1);
    send(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 1'b1);

    // 4:2:2 odd-length line: red, blue, green(last) -> green alone with own U.
    expect_beat(8'd77, 8'd170, 8'd0, 1'b0);
    expect_beat(8'd29, 8'd181, 8'd0, 1'b0);
    expect_beat(8'd149, 8'd43, 8'd0, 1'b1);
    send(8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    send(8'd0, 8'd0, 8'd255, 1'b0, 1'b0, 1'b1);
    send(8'd0, 8'd255, 8'd0, 1'b1, 1'b0, 1'b1);
    cycles(6);

    // Reset after an even 4:2:2 pixel discards it; next line samples fresh mode.
    send(8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("rst_mid_pair_m_valid", {31'b0, m_valid}, 32'd0);
    expect_beat(8'd19, 8'd255, 8'd116, 1'b1);
    send(8'd0, 8'd0, 8'd255, 1'b1, 1'b1, 1'b0);
    cycles(6);

    // Continuous 4:4:4 stream with a 10-cycle output stall.
    for (int i = 0; i < 12; i++) begin
      expect_beat(col_y[i % 6], col_u[i % 6], col_v[i % 6], (i == 11));
    end
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send(col_r[i % 6], col_g[i % 6], col_b[i % 6], (i == 11), 1'b0, 1'b0);
        end
      end
      begin
        cycles(6);
        m_ready = 1'b0;
        cycles(1);
        chk("stall_s_ready_drop", {31'b0, s_ready}, 32'd0);
        cycles(9);
        m_ready = 1'b1;
      end
    join

    for (int i = 0; i < 300 && sb.size() > 0; i++) begin
      cycles(1);
    end
    cycles(2);
    chk("drain_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
